data_memory: RTL and testbench



---
 rtl/mem_pkg.sv | 36 +++
 rtl/data_memory.sv | 75 +++++++
 tb/tb_data_memory.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//
// Purpose:
//   Shared definitions for the CPU memories (data memory and instruction
//   memory). Both memories map a byte address to a word index in the same way,
//   so that mapping lives here as a single function.
//
// Contents:
//   DATA_WIDTH   word width in bits
//   DEPTH        number of words (power of two)
//   ADDR_WIDTH   byte-address width
//   INDEX_WIDTH  log2(DEPTH), width of a word index
//   word_t       one memory word
//   index_t      one word index
//   word_index() byte address -> word index (address[INDEX_WIDTH+1:2])
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int DEPTH       = 1024;
   localparam int ADDR_WIDTH  = 32;
   localparam int INDEX_WIDTH = $clog2(DEPTH);

   typedef logic [DATA_WIDTH-1:0]  word_t;
   typedef logic [INDEX_WIDTH-1:0] index_t;

   // The two byte-offset bits and everything above the index are dropped:
   // accesses are always word-aligned and addresses wrap modulo the array size.
   function automatic index_t word_index(input logic [ADDR_WIDTH-1:0] address);
      logic unused_bits;
      unused_bits = ^{address[ADDR_WIDTH-1:INDEX_WIDTH+2], address[1:0]};
      return address[INDEX_WIDTH+1:2];
   endfunction

endpackage

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Purpose:
//   Word-addressed data memory for the MEM stage of the pipelined MIPS CPU.
//   DEPTH x DATA_WIDTH storage, combinational read, synchronous write on the
//   rising clock edge, asynchronous active-high reset that clears every word.
//
// Ports:
//   clock         in   1           rising-edge clock
//   reset         in   1           asynchronous, active-high; clears all words
//   address       in   ADDR_WIDTH  byte address (bits [1:0] and bits above the
//                                  word index are ignored)
//   writeEnabled  in   1           write strobe, sampled at posedge clock
//   writeInput    in   DATA_WIDTH  write data
//   readResult    out  DATA_WIDTH  word currently selected by address
//
// Write strobe semantics: a write is a single-cycle strobe with no
// back-pressure. Whenever writeEnabled is 1 and reset is 0 at a rising edge of
// clock, the selected word takes writeInput at that edge; there is no ready or
// acknowledge and no stall.
// -----------------------------------------------------------------------------
module data_memory #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  writeEnabled,
   input  logic [DATA_WIDTH-1:0] writeInput,
   output logic [DATA_WIDTH-1:0] readResult
);

   import mem_pkg::*;

   localparam int IDX_W = $clog2(DEPTH);

   logic [IDX_W-1:0]      index;
   logic [DATA_WIDTH-1:0] words [DEPTH];

   // At the shared default geometry the package function is the one source of
   // the address-to-index mapping; other geometries use the equivalent slice.
   if (DEPTH == mem_pkg::DEPTH && ADDR_WIDTH == mem_pkg::ADDR_WIDTH)
   begin : g_pkg_index
      assign index = word_index(address);
   end else begin : g_local_index
      logic unused_addr_bits;
      assign unused_addr_bits = ^{address[ADDR_WIDTH-1:IDX_W+2], address[1:0]};
      assign index = address[IDX_W+1:2];
   end

   // One register per word so the asynchronous clear is a plain per-register
   // reset rather than a loop over the whole array. Reset has priority, so a
   // write edge that coincides with reset high is discarded.
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      localparam logic [IDX_W-1:0] WORD_IDX = IDX_W'(g);
      logic [DATA_WIDTH-1:0] word_q;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            word_q <= '0;
         end else if (writeEnabled && (index == WORD_IDX)) begin
            word_q <= writeInput;
         end
      end

      assign words[g] = word_q;
   end

   // No write-through bypass: until the capturing edge, the old word is shown.
   assign readResult = words[index];

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Self-checking bench for data_memory. A reference model (an array indexed by
// (address / 4) mod 1024) holds the expected contents; each test task drives
// stimulus and compares readResult against the model inline.
// -----------------------------------------------------------------------------
module tb_data_memory;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int WORDS = 1024;

   logic          clock;
   logic          reset;
   logic [AW-1:0] address;
   logic          writeEnabled;
   logic [DW-1:0] writeInput;
   logic [DW-1:0] readResult;

   logic [DW-1:0] model [WORDS];
   logic [DW-1:0] exp_q [$];

   int n_checks;
   int n_fails;

   data_memory #(
      .DATA_WIDTH(DW),
      .DEPTH     (WORDS),
      .ADDR_WIDTH(AW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .address     (address),
      .writeEnabled(writeEnabled),
      .writeInput  (writeInput),
      .readResult  (readResult)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- model helpers ----------------
   function automatic int model_slot(input logic [AW-1:0] a);
      return int'((a / 4) % WORDS);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < WORDS; i++) model[i] = '0;
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge; the write is taken on the next rising
   // edge and the result is sampled 1 ns later.
   task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      address      = a;
      writeInput   = d;
      writeEnabled = 1'b1;
      @(posedge clock);
      #1;
      writeEnabled = 1'b0;
      if (!reset) model[model_slot(a)] = d;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset        = 1'b1;
      writeEnabled = 1'b0;
      writeInput   = '0;
      address      = '0;
      model_clear();
      #3;
      for (int i = 0; i < WORDS; i++) begin
         address = AW'(i * 4);
         #1;
         n_checks++;
         if (readResult !== '0) begin
            n_fails++;
            $display("FAIL reset_read addr=%h got=%h exp=%h", address, readResult, 32'h0);
         end
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_we_low();
      @(negedge clock);
      address      = 32'h0000_0010;
      writeInput   = 32'hFFFF_FFFF;
      writeEnabled = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      n_checks++;
      if (readResult !== model[model_slot(address)]) begin
         n_fails++;
         $display("FAIL we_low got=%h exp=%h", readResult, model[model_slot(address)]);
      end
   endtask

   task automatic test_alignment();
      logic [AW-1:0] alias_addrs [3];
      alias_addrs[0] = 32'h0000_0009;
      alias_addrs[1] = 32'h0000_000B;
      alias_addrs[2] = 32'h0000_1008;
      drive_write(32'h0000_0008, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         address = alias_addrs[i];
         #1;
         n_checks++;
         if (readResult !== 32'hDEAD_BEEF) begin
            n_fails++;
            $display("FAIL alias addr=%h got=%h exp=%h", address, readResult, 32'hDEAD_BEEF);
         end
      end
   endtask

   task automatic test_read_during_write();
      drive_write(32'h0000_0020, 32'h1111_1111);
      @(negedge clock);
      address      = 32'h0000_0020;
      writeInput   = 32'h2222_2222;
      writeEnabled = 1'b1;
      #1;
      n_checks++;
      if (readResult !== 32'h1111_1111) begin
         n_fails++;
         $display("FAIL rdw_before got=%h exp=%h", readResult, 32'h1111_1111);
      end
      @(posedge clock);
      #1;
      writeEnabled = 1'b0;
      model[model_slot(32'h20)] = 32'h2222_2222;
      n_checks++;
      if (readResult !== 32'h2222_2222) begin
         n_fails++;
         $display("FAIL rdw_after got=%h exp=%h", readResult, 32'h2222_2222);
      end
   endtask

   task automatic test_full_sweep();
      logic [DW-1:0] d;
      logic [DW-1:0] e;
      exp_q.delete();
      for (int i = 0; i < WORDS; i++) begin
         d = $urandom;
         drive_write(AW'(i * 4), d);
         exp_q.push_back(d);
      end
      for (int i = 0; i < WORDS; i++) begin
         @(negedge clock);
         address = AW'(i * 4);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (readResult !== e) begin
            n_fails++;
            $display("FAIL sweep addr=%h got=%h exp=%h", address, readResult, e);
         end
      end
   endtask

   // Random writes on consecutive edges, random offset and high address bits,
   // with some deliberate repeats of the same word; last write must win.
   task automatic test_back_to_back();
      logic [AW-1:0] a;
      logic [AW-1:0] prev;
      prev = 32'h0000_0100;
      @(negedge clock);
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 3) == 0) a = prev ^ (32'h1 << 12) ^ 32'h3 & 32'h3;
         else a = $urandom;
         address      = a;
         writeInput   = $urandom;
         writeEnabled = 1'b1;
         model[model_slot(a)] = writeInput;
         prev = a;
         @(negedge clock);
      end
      writeEnabled = 1'b0;
      for (int i = 0; i < 64; i++) begin
         address = $urandom;
         #1;
         n_checks++;
         if (readResult !== model[model_slot(address)]) begin
            n_fails++;
            $display("FAIL b2b addr=%h got=%h exp=%h", address, readResult,
                     model[model_slot(address)]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] d;
      // Make sure the word we watch is nonzero before reset.
      drive_write(32'h0000_0040, 32'hA5A5_5A5A);
      @(negedge clock);
      address = 32'h0000_0040;
      #2;
      n_checks++;
      if (readResult !== 32'hA5A5_5A5A) begin
         n_fails++;
         $display("FAIL pre_reset got=%h exp=%h", readResult, 32'hA5A5_5A5A);
      end
      reset = 1'b1;
      model_clear();
      #1;
      n_checks++;
      if (readResult !== '0) begin
         n_fails++;
         $display("FAIL async_clear got=%h exp=%h", readResult, 32'h0);
      end
      // Write strobed while reset is high must be discarded.
      writeInput   = 32'h1234_5678;
      writeEnabled = 1'b1;
      @(posedge clock);
      #1;
      n_checks++;
      if (readResult !== '0) begin
         n_fails++;
         $display("FAIL write_in_reset got=%h exp=%h", readResult, 32'h0);
      end
      // First edge with reset low performs the pending write.
      @(negedge clock);
      d            = $urandom;
      address      = 32'h0000_0080;
      writeInput   = d;
      writeEnabled = 1'b1;
      reset        = 1'b0;
      @(posedge clock);
      #1;
      writeEnabled = 1'b0;
      model[model_slot(32'h80)] = d;
      n_checks++;
      if (readResult !== d) begin
         n_fails++;
         $display("FAIL first_write_after_reset got=%h exp=%h", readResult, d);
      end
      for (int i = 0; i < WORDS; i++) begin
         address = AW'(i * 4);
         #1;
         n_checks++;
         if (readResult !== model[i]) begin
            n_fails++;
            $display("FAIL post_reset addr=%h got=%h exp=%h", address, readResult, model[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks = 0;
      n_fails  = 0;
      test_reset();
      test_we_low();
      test_alignment();
      test_read_during_write();
      test_full_sweep();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
